// File: rtl/vend_pkg.sv
// Shared types and coin encoding for the multi-product vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    // Coin code to credit units (1 unit = 5 rs).
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 3'd1;
            COIN_10: return 3'd2;
            COIN_20: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_payout.sv
// Greedy change-coin presenter with ready/valid handshake; reports units paid out this cycle.
module vend_payout
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                active_d,
    input  logic [CREDIT_W-1:0] credit_d,
    input  logic                change_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [1:0]          pay_dec
);

    logic       valid_q;
    logic [1:0] coin_q;

    // The coin for the next cycle is picked from the post-handshake credit so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            coin_q  <= COIN_NONE;
        end else begin
            valid_q <= active_d;
            if (!active_d) begin
                coin_q <= COIN_NONE;
            end else if (credit_d >= CREDIT_W'(2)) begin
                coin_q <= COIN_10;
            end else begin
                coin_q <= COIN_5;
            end
        end
    end

    always_comb begin
        pay_dec = 2'd0;
        if (valid_q && change_ready) begin
            pay_dec = (coin_q == COIN_10) ? 2'd2 : 2'd1;
        end
    end

    assign change_valid = valid_q;
    assign change_coin  = coin_q;

endmodule

// File: rtl/vend_ctrl.sv
// Multi-product vending controller: credit accumulation, per-product price/stock, vend and change payout.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int                          N_PROD     = 4,
    parameter int                          CREDIT_W   = 8,
    parameter int                          MAX_CREDIT = 40,
    parameter logic [N_PROD*CREDIT_W-1:0]  PRICES     = {8'd6, 8'd5, 8'd4, 8'd3},
    parameter int                          STOCK_W    = 4,
    parameter int                          INIT_STOCK = 15,
    localparam int                         SEL_W      = $clog2(N_PROD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                restock,
    input  logic [SEL_W-1:0]    restock_id,
    input  logic                change_ready,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispense_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_PROD-1:0]   sold_out,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy
);

    localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    dispense_id_q, dispense_id_d;
    logic                dispense_q, coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d, busy_q;
    logic [N_PROD-1:0]   take, restock_hit;
    logic [CREDIT_W-1:0] price [N_PROD];
    logic [CREDIT_W-1:0] coin_val, sel_price;
    logic [CREDIT_W:0]   coin_sum;
    logic                sel_in_range, coin_present;
    logic [1:0]          pay_dec;

    genvar gi;
    generate
        for (gi = 0; gi < N_PROD; gi++) begin : g_prod
            logic [STOCK_W-1:0] stock_q;

            assign price[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];

            always_ff @(posedge clk) begin
                if (rst || restock_hit[gi]) begin
                    stock_q <= STOCK_W'(INIT_STOCK);
                end else if (take[gi]) begin
                    stock_q <= stock_q - STOCK_W'(1);
                end
            end

            assign sold_out[gi] = (stock_q == '0);
        end
    endgenerate

    assign coin_present = (coin != COIN_NONE);
    assign coin_val     = CREDIT_W'(coin_value(coin));
    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
    assign sel_in_range = (int'(sel) < N_PROD);
    assign sel_price    = sel_in_range ? price[sel] : '0;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        dispense_id_d = dispense_id_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        take          = '0;
        restock_hit   = '0;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (state_q == ST_IDLE && restock && int'(restock_id) < N_PROD) begin
                    restock_hit[restock_id] = 1'b1;
                end
                if (cancel) begin
                    coin_reject_d = coin_present;
                    if (credit_q != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_present;
                    if (!sel_in_range || sold_out[sel] || credit_q < sel_price) begin
                        sel_err_d = 1'b1;
                    end else begin
                        credit_d      = credit_q - sel_price;
                        take[sel]     = 1'b1;
                        dispense_id_d = sel;
                        state_d       = ST_VEND;
                    end
                end else if (coin_present) begin
                    if (coin_sum > MAX_SUM) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_present;
                state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            default: begin
                coin_reject_d = coin_present;
                credit_d      = credit_q - CREDIT_W'(pay_dec);
                if (credit_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            dispense_id_q <= '0;
            dispense_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_id_q <= dispense_id_d;
            dispense_q    <= (state_d == ST_VEND);
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            busy_q        <= (state_d == ST_VEND) || (state_d == ST_CHANGE);
        end
    end

    vend_payout #(
        .CREDIT_W (CREDIT_W)
    ) u_payout (
        .clk          (clk),
        .rst          (rst),
        .active_d     (state_d == ST_CHANGE),
        .credit_d     (credit_d),
        .change_ready (change_ready),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .pay_dec      (pay_dec)
    );

    assign dispense    = dispense_q;
    assign dispense_id = dispense_id_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed scenarios plus randomized traffic against a transaction-level vending model.
module tb_vend_ctrl;

    localparam int PRICE [4] = '{3, 4, 5, 6};
    localparam int MAXC = 40;
    localparam int INIT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [1:0] restock_id = 2'd0;
    logic       change_ready = 1'b1;
    logic       dispense;
    logic [1:0] dispense_id;
    logic       change_valid;
    logic [1:0] change_coin;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       coin_reject;
    logic       sel_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: credit in units, stock per product, "vend pending" and "refund in progress" flags.
    int m_credit;
    int m_stock [4];
    bit m_vend;
    int m_vid;
    bit m_pay;
    bit e_rej;
    bit e_serr;

    always #5 clk = ~clk;

    vend_ctrl #(
        .N_PROD     (4),
        .CREDIT_W   (8),
        .MAX_CREDIT (40),
        .PRICES     ({8'd6, 8'd5, 8'd4, 8'd3}),
        .STOCK_W    (4),
        .INIT_STOCK (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .restock      (restock),
        .restock_id   (restock_id),
        .change_ready (change_ready),
        .dispense     (dispense),
        .dispense_id  (dispense_id),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .credit       (credit),
        .sold_out     (sold_out),
        .coin_reject  (coin_reject),
        .sel_err      (sel_err),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = INIT;
        m_vend = 0;
        m_vid  = 0;
        m_pay  = 0;
        e_rej  = 0;
        e_serr = 0;
    endtask

    function automatic int units(input logic [1:0] c);
        return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 4 : 0;
    endfunction

    task automatic model_step();
        int v;
        int paid;
        if (rst) begin
            model_reset();
            return;
        end
        e_rej  = 0;
        e_serr = 0;
        if (m_vend) begin
            e_rej  = (coin != 2'b00);
            m_vend = 0;
            m_pay  = (m_credit > 0);
        end else if (m_pay) begin
            e_rej = (coin != 2'b00);
            if (change_ready) begin
                paid = (m_credit >= 2) ? 2 : 1;
                m_credit -= paid;
                $display("[%0t] payout %0d rs, credit left %0d", $time, paid * 5, m_credit);
                if (m_credit == 0) m_pay = 0;
            end
        end else begin
            if (m_credit == 0 && restock) m_stock[restock_id] = INIT;
            if (cancel) begin
                e_rej = (coin != 2'b00);
                if (m_credit > 0) m_pay = 1;
            end else if (sel_valid) begin
                e_rej = (coin != 2'b00);
                if (m_stock[sel] == 0 || m_credit < PRICE[sel]) begin
                    e_serr = 1;
                end else begin
                    m_credit -= PRICE[sel];
                    m_stock[sel]--;
                    m_vend = 1;
                    m_vid  = sel;
                    $display("[%0t] vend product %0d, credit left %0d", $time, m_vid, m_credit);
                end
            end else if (coin != 2'b00) begin
                v = units(coin);
                if (m_credit + v > MAXC) e_rej = 1;
                else m_credit += v;
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_so;
        for (int i = 0; i < 4; i++) e_so[i] = (m_stock[i] == 0);
        check("credit", credit, m_credit);
        check("dispense", dispense, m_vend);
        if (m_vend) check("dispense_id", dispense_id, m_vid);
        check("change_valid", change_valid, m_pay);
        check("change_coin", change_coin, !m_pay ? 0 : (m_credit >= 2) ? 2 : 1);
        check("coin_reject", coin_reject, e_rej);
        check("sel_err", sel_err, e_serr);
        check("busy", busy, m_vend || m_pay);
        check("sold_out", sold_out, e_so);
    endtask

    task automatic tick(input logic [1:0] c, input bit sv, input int s, input bit cn,
                        input bit rs, input int rid, input bit rdy, input bit r);
        coin         = c;
        sel_valid    = sv;
        sel          = 2'(s);
        cancel       = cn;
        restock      = rs;
        restock_id   = 2'(rid);
        change_ready = rdy;
        rst          = r;
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        tick(2'b00, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic put_coin(input logic [1:0] c);
        tick(c, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic select(input int s);
        tick(2'b00, 1, s, 0, 0, 0, 1, 0);
    endtask

    task automatic refund_all();
        tick(2'b00, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            if (!busy && credit == 0) break;
            idle(1);
        end
        check("drain_credit", credit, 0);
    endtask

    initial begin
        model_reset();
        tick(2'b00, 0, 0, 0, 0, 0, 1, 1);
        check("rst_credit", credit, 0);
        check("rst_sold_out", sold_out, 0);
        check("rst_busy", busy, 0);

        // Exact payment, no change.
        put_coin(2'b10);
        put_coin(2'b01);
        check("t1_credit3", credit, 3);
        select(0);
        check("t1_dispense", dispense, 1);
        check("t1_id", dispense_id, 0);
        check("t1_credit0", credit, 0);
        idle(1);
        check("t1_no_change", change_valid, 0);

        // Overpay, one 10 rs coin back.
        put_coin(2'b11);
        put_coin(2'b11);
        select(3);
        check("t2_dispense", dispense, 1);
        check("t2_credit", credit, 2);
        idle(1);
        check("t2_coin10", change_coin, 2);
        idle(1);
        check("t2_done", busy, 0);

        // Cancel with stalled payout.
        put_coin(2'b10);
        put_coin(2'b01);
        tick(2'b00, 0, 0, 1, 0, 0, 1, 0);
        check("t3_first", change_coin, 2);
        idle(0);
        check("t3_stall_coin", change_coin, 2);
        check("t3_stall_credit", credit, 3);
        idle(1);
        check("t3_second", change_coin, 1);
        idle(1);
        check("t3_credit0", credit, 0);

        // Credit ceiling.
        for (int i = 0; i < 9; i++) put_coin(2'b11);
        put_coin(2'b10);
        check("t4_credit38", credit, 38);
        put_coin(2'b11);
        check("t4_reject", coin_reject, 1);
        check("t4_still38", credit, 38);
        put_coin(2'b10);
        check("t4_credit40", credit, 40);
        refund_all();

        // Sell out product 1, refused selection, restock.
        for (int i = 0; i < 15; i++) begin
            put_coin(2'b11);
            select(1);
            idle(1);
        end
        check("t5_sold_out", sold_out[1], 1);
        put_coin(2'b11);
        select(1);
        check("t5_sel_err", sel_err, 1);
        refund_all();
        tick(2'b00, 0, 0, 0, 1, 1, 1, 0);
        check("t5_restocked", sold_out[1], 0);

        // Coin with selection, then reset during payout.
        tick(2'b10, 1, 0, 0, 0, 0, 1, 0);
        check("t6_coin_reject", coin_reject, 1);
        put_coin(2'b11);
        tick(2'b00, 0, 0, 1, 0, 0, 0, 0);
        idle(0);
        check("t6_in_change", change_valid, 1);
        tick(2'b00, 0, 0, 0, 0, 0, 0, 1);
        check("t6_rst_valid", change_valid, 0);
        check("t6_rst_credit", credit, 0);
        check("t6_rst_coin", change_coin, 0);
        check("t6_rst_busy", busy, 0);
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] c;
            bit sv, cn, rs, rdy, r;
            c   = ($urandom_range(0, 99) < 35) ? 2'($urandom_range(1, 3)) : 2'b00;
            sv  = ($urandom_range(0, 99) < 20);
            cn  = ($urandom_range(0, 99) < 5);
            rs  = ($urandom_range(0, 99) < 4);
            rdy = ($urandom_range(0, 99) < 70);
            r   = ($urandom_range(0, 999) < 3);
            tick(c, sv, $urandom_range(0, 3), cn, rs, $urandom_range(0, 3), rdy, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
